// File: rtl/wptr_full_ctrl_if.sv
// Write-side FIFO bus: producer request/clear plus the read-domain Gray pointer in,
// storage strobe/address and write-domain status out.
interface wptr_full_ctrl_if #(
  parameter int ADDR_SIZE = 4
);
  logic                 w_inc;
  logic                 w_clr_ovf;
  logic [ADDR_SIZE:0]   r_ptr_gray;
  logic                 w_en;
  logic [ADDR_SIZE-1:0] w_addr;
  logic [ADDR_SIZE:0]   w_ptr_gray;
  logic                 w_full;
  logic                 w_almost_full;
  logic [ADDR_SIZE:0]   w_level;
  logic                 w_overflow;

  modport master (
    output w_inc, w_clr_ovf, r_ptr_gray,
    input  w_en, w_addr, w_ptr_gray, w_full, w_almost_full, w_level, w_overflow
  );

  modport slave (
    input  w_inc, w_clr_ovf, r_ptr_gray,
    output w_en, w_addr, w_ptr_gray, w_full, w_almost_full, w_level, w_overflow
  );
endinterface

// File: rtl/wptr_full_ctrl.sv
// Async-FIFO write-pointer controller: binary/Gray write pointer, read-pointer
// synchroniser and registered full / almost-full / level / sticky-overflow status.
module wptr_full_ctrl #(
  parameter int ADDR_SIZE   = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = 14
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  wptr_full_ctrl_if.slave   bus
);
  localparam int A = ADDR_SIZE;
  // Top two bits set: a full FIFO's write Gray equals the read Gray with these inverted.
  localparam logic [A:0] FULL_MASK = {(A+1){1'b1}} << (A-1);
  localparam logic [A:0] AF_T      = (A+1)'(AF_THRESH);

  logic [A:0]                   r_bin;
  logic [A:0]                   r_gray;
  logic [SYNC_STAGES-1:0][A:0]  r_sync;
  logic                         r_full;
  logic                         r_af;
  logic [A:0]                   r_level;
  logic                         r_ovf;

  logic       w_wr;
  logic [A:0] w_bin_next;
  logic [A:0] w_gray_next;
  logic [A:0] w_wq_rptr;
  logic [A:0] w_wq_rbin;
  logic [A:0] w_level_next;

  assign w_wr         = bus.w_inc & ~r_full;
  assign w_bin_next   = r_bin + {{A{1'b0}}, w_wr};
  assign w_gray_next  = w_bin_next ^ (w_bin_next >> 1);
  assign w_wq_rptr    = r_sync[SYNC_STAGES-1];
  assign w_level_next = w_bin_next - w_wq_rbin;

  genvar gi;
  generate
    for (gi = 0; gi <= A; gi++) begin : g_g2b
      assign w_wq_rbin[gi] = ^w_wq_rptr[A:gi];
    end
  endgenerate

  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      r_bin   <= '0;
      r_gray  <= '0;
      r_sync  <= '0;
      r_full  <= 1'b0;
      r_af    <= 1'b0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_bin   <= w_bin_next;
      r_gray  <= w_gray_next;
      r_sync  <= {r_sync, bus.r_ptr_gray};
      r_full  <= (w_gray_next == (w_wq_rptr ^ FULL_MASK));
      r_af    <= (w_level_next >= AF_T);
      r_level <= w_level_next;
      // Set term dominates the clear when both occur together.
      r_ovf   <= (bus.w_inc & r_full) | (r_ovf & ~bus.w_clr_ovf);
    end
  end

  assign bus.w_en          = w_wr;
  assign bus.w_addr        = r_bin[A-1:0];
  assign bus.w_ptr_gray    = r_gray;
  assign bus.w_full        = r_full;
  assign bus.w_almost_full = r_af;
  assign bus.w_level       = r_level;
  assign bus.w_overflow    = r_ovf;
endmodule

// File: doc/wptr_full_ctrl.md
Name: wptr_full_ctrl

Overview:
Write-side controller for the asynchronous FIFO, in the w_clk domain directly upstream of fifo_mem. It owns the binary/Gray write pointer and drives the write address and the gated write enable into the storage array. It synchronises the read-domain Gray pointer and produces registered full, almost-full, fill-level and sticky-overflow status.

Parameters:
ADDR_SIZE, 4, storage address width; DEPTH = 2**ADDR_SIZE
SYNC_STAGES, 2, flop stages in the read-pointer synchroniser; legal range 2..4
AF_THRESH, 14, fill level at or above which w_almost_full asserts; legal range 1..DEPTH

Ports:
w_clk  input  1  write-domain clock; all flops rise-edge
w_rst_n  input  1  synchronous active-low reset, sampled on w_clk
w_inc  input  1  producer write request for this cycle
w_clr_ovf  input  1  clears w_overflow
r_ptr_gray  input  ADDR_SIZE+1  read pointer, Gray coded, from read domain (asynchronous to w_clk)
w_en  output  1  write strobe to storage = w_inc & ~w_full (combinational)
w_addr  output  ADDR_SIZE  storage write address = w_bin[ADDR_SIZE-1:0]
w_ptr_gray  output  ADDR_SIZE+1  registered Gray write pointer, to read-domain synchroniser
w_full  output  1  registered full flag
w_almost_full  output  1  registered, level >= AF_THRESH
w_level  output  ADDR_SIZE+1  registered entries in use, 0..DEPTH
w_overflow  output  1  sticky: a write was attempted while full

Behaviour:
- Reset (w_rst_n=0 at a w_clk edge): w_bin, w_ptr_gray, all synchroniser stages, w_full, w_almost_full, w_level and w_overflow go to 0. w_addr is then 0 and w_en follows w_inc. Reset mid-operation discards all state; no partial write occurs because the storage write is gated by w_en.
- Pointer: w_bin_next = w_bin + (w_inc & ~w_full), modulo 2**(ADDR_SIZE+1). Gray next = w_bin_next ^ (w_bin_next >> 1). w_bin and w_ptr_gray update together every cycle.
- Synchroniser: r_ptr_gray passes through SYNC_STAGES flops to give wq_rptr. No logic is placed between the stages. wq_rptr is converted to binary wq_rbin by an XOR prefix from the MSB.
- Full: w_full <= (gray_next == {~wq_rptr[A:A-1], wq_rptr[A-2:0]}), where A = ADDR_SIZE. For ADDR_SIZE=1 the comparison uses only the inverted top two bits. Full therefore asserts on the same edge as the write that fills the FIFO, with no bubble. Deassertion lags the read by SYNC_STAGES+1 w_clk edges (pessimistic, safe).
- Level: w_level <= (w_bin_next - wq_rbin) mod 2**(A+1). w_almost_full <= (that value >= AF_THRESH). Both are registered from next-state values, so they are coherent with w_full.
- Overflow: a w_inc while w_full=1 is dropped; the pointer does not move and w_en=0. w_overflow <= 1 on the following edge and holds until w_clr_ovf=1. If set and clear coincide on the same edge, set wins.
- Wrap-around: pointers wrap naturally at 2**(A+1). The extra MSB disambiguates full from empty. w_addr wraps from DEPTH-1 to 0.
- Simultaneous write and read-pointer change: the level uses the synchronised value, so it can over-report by up to the synchroniser delay. It never under-reports.
- Invariants: w_level <= DEPTH; w_full == (w_level == DEPTH); w_ptr_gray changes at most one bit per cycle.

Test Plan:
- Reset: hold w_rst_n=0 for 3 cycles with w_inc=1 and r_ptr_gray=5'b10101 -> after release, w_ptr_gray=0, w_level=0, w_full=0, w_overflow=0, w_addr=0.
- Fill (ADDR_SIZE=4, r_ptr_gray=0): 16 consecutive w_inc -> w_addr steps 0..15; w_almost_full rises after the 14th write; w_full=1 and w_level=16 on the 16th edge; w_ptr_gray=5'b11000.
- Overflow: while full, pulse w_inc for 2 cycles -> w_en=0, pointer holds at 5'b11000, w_overflow=1. Assert w_clr_ovf together with a w_inc -> w_overflow stays 1. Assert w_clr_ovf alone -> w_overflow=0.
- Drain visibility: while full, set r_ptr_gray=5'b00001 (one read) -> w_full drops exactly SYNC_STAGES+1 edges later and w_level=15. One further write refills the FIFO, with w_full=1 on that edge.
- Wrap: with writes and reads interleaved, walk the pointer past 31 back to 0 -> w_addr wraps 15->0, the MSB toggles, and w_full/w_level stay correct. A Gray single-bit-change check holds on every edge.
- Reset mid-fill: at w_level=9, pulse w_rst_n=0 for 1 cycle -> the next edge shows all outputs at 0, and the following write lands at w_addr=0.
